// File: rtl/wb_commit_unit.sv
// wb_commit_unit: buffers integer and FP writeback results in per-stream FIFOs
// and commits at most one register-file write per cycle with round-robin arbitration.
`default_nettype none

module wb_commit_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [36:0]      wdata_i,
  input  logic             pop_i,
  output logic [36:0]      rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             ready_o
);

  localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [36:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_push;

  // Readiness comes only from the registered count, so a full FIFO refuses
  // a push even in a cycle where it also pops.
  assign ready_o = (count_q != C_FULL);
  assign w_push  = push_i & ready_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    if (w_push && !pop_i) begin
      count_d = count_q + C_CNT_ONE;
    end else if (!w_push && pop_i) begin
      count_d = count_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

module wb_commit_unit #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_valid,
  output logic             int_ready,
  input  logic [4:0]       int_rd,
  input  logic [31:0]      int_alu_result,
  input  logic [31:0]      int_load_data,
  input  logic             int_wb_sel,
  input  logic             fp_valid,
  output logic             fp_ready,
  input  logic [4:0]       fp_rd,
  input  logic [31:0]      fp_falu_result,
  input  logic [31:0]      fp_load_data,
  input  logic             fp_wb_sel,
  output logic             wb_int_we,
  output logic             wb_fp_we,
  output logic [4:0]       wb_rd_addr,
  output logic [31:0]      wb_int_data,
  output logic [31:0]      wb_fp_data,
  output logic [PTR_W:0]   int_count,
  output logic [PTR_W:0]   fp_count
);

  logic [36:0] w_int_wdata, w_fp_wdata;
  logic [36:0] w_int_head, w_fp_head;
  logic        w_int_ne, w_fp_ne;
  logic        w_pop_int, w_pop_fp;

  logic        rr_q, rr_d;
  logic        int_we_q, int_we_d;
  logic        fp_we_q, fp_we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] int_data_q, int_data_d;
  logic [31:0] fp_data_q, fp_data_d;

  assign w_int_wdata = {int_rd, int_wb_sel ? int_load_data : int_alu_result};
  assign w_fp_wdata  = {fp_rd, fp_wb_sel ? fp_load_data : fp_falu_result};

  wb_commit_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_int_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (int_valid),
    .wdata_i (w_int_wdata),
    .pop_i   (w_pop_int),
    .rdata_o (w_int_head),
    .count_o (int_count),
    .ready_o (int_ready)
  );

  wb_commit_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fp_valid),
    .wdata_i (w_fp_wdata),
    .pop_i   (w_pop_fp),
    .rdata_o (w_fp_head),
    .count_o (fp_count),
    .ready_o (fp_ready)
  );

  assign w_int_ne = (int_count != '0);
  assign w_fp_ne  = (fp_count != '0);

  // rr_q = 0 favours the integer stream; it flips only on contested cycles.
  always_comb begin
    w_pop_int  = w_int_ne & (~w_fp_ne | ~rr_q);
    w_pop_fp   = w_fp_ne & ~w_pop_int;
    rr_d       = (w_int_ne & w_fp_ne) ? ~rr_q : rr_q;
    int_we_d   = 1'b0;
    fp_we_d    = 1'b0;
    addr_d     = addr_q;
    int_data_d = int_data_q;
    fp_data_d  = fp_data_q;
    if (w_pop_int) begin
      int_we_d   = (w_int_head[36:32] != 5'd0);
      addr_d     = w_int_head[36:32];
      int_data_d = w_int_head[31:0];
    end else if (w_pop_fp) begin
      fp_we_d    = 1'b1;
      addr_d     = w_fp_head[36:32];
      fp_data_d  = w_fp_head[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      int_we_q   <= 1'b0;
      fp_we_q    <= 1'b0;
      addr_q     <= '0;
      int_data_q <= '0;
      fp_data_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      int_we_q   <= int_we_d;
      fp_we_q    <= fp_we_d;
      addr_q     <= addr_d;
      int_data_q <= int_data_d;
      fp_data_q  <= fp_data_d;
    end
  end

  assign wb_int_we   = int_we_q;
  assign wb_fp_we    = fp_we_q;
  assign wb_rd_addr  = addr_q;
  assign wb_int_data = int_data_q;
  assign wb_fp_data  = fp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed plus random stimulus against a queue-based
// reference model; a negedge monitor compares every cycle's registered writeback.
`default_nettype none

module tb_wb_commit_unit;

  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             int_valid, int_wb_sel, fp_valid, fp_wb_sel;
  logic [4:0]       int_rd, fp_rd;
  logic [31:0]      int_alu_result, int_load_data, fp_falu_result, fp_load_data;
  logic             int_ready, fp_ready, wb_int_we, wb_fp_we;
  logic [4:0]       wb_rd_addr;
  logic [31:0]      wb_int_data, wb_fp_data;
  logic [PTR_W:0]   int_count, fp_count;

  wb_commit_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .int_valid      (int_valid),
    .int_ready      (int_ready),
    .int_rd         (int_rd),
    .int_alu_result (int_alu_result),
    .int_load_data  (int_load_data),
    .int_wb_sel     (int_wb_sel),
    .fp_valid       (fp_valid),
    .fp_ready       (fp_ready),
    .fp_rd          (fp_rd),
    .fp_falu_result (fp_falu_result),
    .fp_load_data   (fp_load_data),
    .fp_wb_sel      (fp_wb_sel),
    .wb_int_we      (wb_int_we),
    .wb_fp_we       (wb_fp_we),
    .wb_rd_addr     (wb_rd_addr),
    .wb_int_data    (wb_int_data),
    .wb_fp_data     (wb_fp_data),
    .int_count      (int_count),
    .fp_count       (fp_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-stream queues of {rd,data}, a round-robin preference
  // bit, and the last written address/data values.
  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  typedef struct { bit iwe; bit fwe; logic [4:0] a; logic [31:0] id; logic [31:0] fd; } exp_t;

  ent_t        mq_i[$];
  ent_t        mq_f[$];
  exp_t        expq[$];
  bit          m_rr;
  logic [4:0]  m_addr;
  logic [31:0] m_id, m_fd;
  ent_t        m_ent;
  exp_t        m_e, mon_e;
  int          m_ni, m_nf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_i.delete();
      mq_f.delete();
      expq.delete();
      m_rr   = 1'b0;
      m_addr = '0;
      m_id   = '0;
      m_fd   = '0;
    end else begin
      m_ni  = mq_i.size();
      m_nf  = mq_f.size();
      m_e.iwe = 1'b0;
      m_e.fwe = 1'b0;
      if (m_ni > 0 && (m_nf == 0 || !m_rr)) begin
        m_ent   = mq_i.pop_front();
        m_addr  = m_ent.rd;
        m_id    = m_ent.d;
        m_e.iwe = (m_ent.rd != 5'd0);
      end else if (m_nf > 0) begin
        m_ent   = mq_f.pop_front();
        m_addr  = m_ent.rd;
        m_fd    = m_ent.d;
        m_e.fwe = 1'b1;
      end
      if (m_ni > 0 && m_nf > 0) m_rr = !m_rr;
      if (int_valid && m_ni < DEPTH)
        mq_i.push_back({int_rd, int_wb_sel ? int_load_data : int_alu_result});
      if (fp_valid && m_nf < DEPTH)
        mq_f.push_back({fp_rd, fp_wb_sel ? fp_load_data : fp_falu_result});
      m_e.a  = m_addr;
      m_e.id = m_id;
      m_e.fd = m_fd;
      expq.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (!rst && expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("wb_int_we", 32'(wb_int_we), 32'(mon_e.iwe));
      check("wb_fp_we", 32'(wb_fp_we), 32'(mon_e.fwe));
      check("wb_rd_addr", 32'(wb_rd_addr), 32'(mon_e.a));
      check("wb_int_data", wb_int_data, mon_e.id);
      check("wb_fp_data", wb_fp_data, mon_e.fd);
      check("int_count", 32'(int_count), 32'(mq_i.size()));
      check("fp_count", 32'(fp_count), 32'(mq_f.size()));
      check("int_ready", 32'(int_ready), 32'(mq_i.size() < DEPTH));
      check("fp_ready", 32'(fp_ready), 32'(mq_f.size() < DEPTH));
    end
  end

  task automatic drive(input logic iv, input logic [4:0] ird, input logic [31:0] ialu,
                       input logic [31:0] iload, input logic isel,
                       input logic fv, input logic [4:0] frd, input logic [31:0] ffalu,
                       input logic [31:0] fload, input logic fsel);
    @(negedge clk);
    int_valid = iv;  int_rd = ird;  int_alu_result = ialu;  int_load_data = iload;  int_wb_sel = isel;
    fp_valid  = fv;  fp_rd  = frd;  fp_falu_result = ffalu; fp_load_data  = fload;  fp_wb_sel  = fsel;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_int_we"}, 32'(wb_int_we), 32'd0);
    check({tag, "_fp_we"}, 32'(wb_fp_we), 32'd0);
    check({tag, "_addr"}, 32'(wb_rd_addr), 32'd0);
    check({tag, "_int_data"}, wb_int_data, 32'd0);
    check({tag, "_fp_data"}, wb_fp_data, 32'd0);
    check({tag, "_int_count"}, 32'(int_count), 32'd0);
    check({tag, "_fp_count"}, 32'(fp_count), 32'd0);
    check({tag, "_int_ready"}, 32'(int_ready), 32'd1);
    check({tag, "_fp_ready"}, 32'(fp_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    int_valid = 0; int_rd = '0; int_alu_result = '0; int_load_data = '0; int_wb_sel = 0;
    fp_valid  = 0; fp_rd  = '0; fp_falu_result = '0; fp_load_data  = '0; fp_wb_sel  = 0;
    #1;
    check_reset_state("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single integer write
    drive(1, 5'd5, 32'h0000_00AA, 32'h0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    idle(4);

    // Contention: int (load path) and fp (FALU path) in the same cycle
    drive(1, 5'd3, 32'h0, 32'h1111_1111, 1, 1, 5'd7, 32'h3F80_0000, 32'h0, 0);
    idle(4);

    // Full/backpressure: both streams held valid for four cycles
    for (int i = 0; i < 4; i++)
      drive(1, 5'(i + 1), 32'(32'h100 + i), 32'h0, 0,
            1, 5'(i + 11), 32'(32'h200 + i), 32'(32'h300 + i), i[0]);
    idle(6);

    // x0 suppression, followed by a normal integer entry
    drive(1, 5'd0, 32'hDEAD_BEEF, 32'h0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    drive(1, 5'd9, 32'h0000_0099, 32'h0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    drive(0, 5'd0, 32'd0, 32'd0, 0, 1, 5'd0, 32'h0F0F_0F0F, 32'd0, 0);
    idle(4);

    // Wrap-around: ten back-to-back FP entries
    for (int i = 1; i <= 10; i++)
      drive(0, 5'd0, 32'd0, 32'd0, 0, 1, 5'(i), 32'(32'hF000 + i), 32'h0, 0);
    idle(4);

    // Asynchronous reset with one entry buffered in each FIFO
    drive(1, 5'd4, 32'h4444, 32'h0, 0, 1, 5'd6, 32'h6666, 32'h0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    int_valid = 0;
    fp_valid  = 0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(4);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
            1'($urandom_range(0, 1)));
    idle(8);

    check("final_int_empty", 32'(int_count), 32'd0);
    check("final_fp_empty", 32'(fp_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
